// File: rtl/div_sign_ctrl.sv
// -----------------------------------------------------------------------------
// div_sign_ctrl
// Signed-division sequencer between the ALU operand bus and an unsigned
// combinational divider core. The core is given operand magnitudes, is allowed
// CORE_LAT cycles to settle, and then the sign-corrected quotient (LO) and
// remainder (HI) are registered for HI/LO write-back. A zero divisor bypasses
// the core and produces HI = dividend, LO = all ones, div_zero = 1.
//
// Ports
//   clk            in   system clock, rising edge
//   clr_n          in   asynchronous active-low reset
//   start          in   request, sampled only in IDLE or DONE
//   dividend       in   signed dividend, sampled with start
//   divisor        in   signed divisor, sampled with start
//   core_dividend  out  registered |dividend| to the core
//   core_divisor   out  registered |divisor| to the core
//   core_quotient  in   unsigned quotient from the core
//   busy           out  high while waiting for the core
//   done           out  one-cycle pulse, hi/lo/div_zero valid
//   div_zero       out  last result came from a zero divisor
//   hi             out  signed remainder
//   lo             out  signed quotient
// -----------------------------------------------------------------------------
module div_sign_ctrl #(
    parameter int WIDTH    = 32,
    parameter int CORE_LAT = 2
) (
    input  logic             clk,
    input  logic             clr_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] core_dividend,
    output logic [WIDTH-1:0] core_divisor,
    input  logic [WIDTH-1:0] core_quotient,
    output logic             busy,
    output logic             done,
    output logic             div_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = (CORE_LAT > 1) ? $clog2(CORE_LAT) : 1;

    localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
    localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
    localparam logic [WIDTH-1:0] ONE_W  = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(CORE_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Two's-complement negate, modulo 2^WIDTH.
    function automatic logic [WIDTH-1:0] neg_w(input logic [WIDTH-1:0] v);
        neg_w = ~v + ONE_W;
    endfunction

    // Magnitude as an unsigned value; the most negative input maps to
    // 2^(WIDTH-1), which is representable unsigned and divides correctly.
    function automatic logic [WIDTH-1:0] abs_mag(input logic [WIDTH-1:0] v);
        abs_mag = v[WIDTH-1] ? neg_w(v) : v;
    endfunction

    state_e           state_q,         state_d;
    logic [CNT_W-1:0] count_q,         count_d;
    logic [WIDTH-1:0] core_dividend_q, core_dividend_d;
    logic [WIDTH-1:0] core_divisor_q,  core_divisor_d;
    logic [WIDTH-1:0] dividend_q,      dividend_d;
    logic [WIDTH-1:0] divisor_q,       divisor_d;
    logic             q_neg_q,         q_neg_d;
    logic             busy_q,          busy_d;
    logic             done_q,          done_d;
    logic             div_zero_q,      div_zero_d;
    logic [WIDTH-1:0] hi_q,            hi_d;
    logic [WIDTH-1:0] lo_q,            lo_d;

    logic [WIDTH-1:0] lo_calc_s;
    logic [WIDTH-1:0] prod_s;
    logic [WIDTH-1:0] hi_calc_s;

    // Sign-corrected quotient and the remainder derived from it. Taking the
    // remainder as dividend - q*divisor (low WIDTH bits) gives it the
    // dividend's sign and makes INT_MIN / -1 wrap to hi = 0 naturally.
    always_comb begin
        lo_calc_s = q_neg_q ? neg_w(core_quotient) : core_quotient;
        prod_s    = lo_calc_s * divisor_q;
        hi_calc_s = dividend_q - prod_s;
    end

    // Next-state and next-output logic for the sequencer.
    always_comb begin
        state_d         = state_q;
        count_d         = count_q;
        core_dividend_d = core_dividend_q;
        core_divisor_d  = core_divisor_q;
        dividend_d      = dividend_q;
        divisor_d       = divisor_q;
        q_neg_d         = q_neg_q;
        div_zero_d      = div_zero_q;
        hi_d            = hi_q;
        lo_d            = lo_q;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                if (start) begin
                    if (divisor != ZERO_W) begin
                        core_dividend_d = abs_mag(dividend);
                        core_divisor_d  = abs_mag(divisor);
                        dividend_d      = dividend;
                        divisor_d       = divisor;
                        q_neg_d         = dividend[WIDTH-1] ^ divisor[WIDTH-1];
                        count_d         = CNT_LOAD;
                        state_d         = ST_WAIT;
                    end else begin
                        // Zero divisor: result is immediate, core untouched.
                        hi_d       = dividend;
                        lo_d       = ONES_W;
                        div_zero_d = 1'b1;
                        state_d    = ST_DONE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (count_q == CNT_ZERO) begin
                    lo_d       = lo_calc_s;
                    hi_d       = hi_calc_s;
                    div_zero_d = 1'b0;
                    state_d    = ST_DONE;
                end else begin
                    count_d = count_q - CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                count_d = CNT_ZERO;
            end
        endcase

        // Status flags are registered from the next state so they line up
        // exactly with the state they describe.
        busy_d = (state_d == ST_WAIT);
        done_d = (state_d == ST_DONE);
    end

    // State and datapath registers.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_q         <= ST_IDLE;
            count_q         <= CNT_ZERO;
            core_dividend_q <= ZERO_W;
            core_divisor_q  <= ZERO_W;
            dividend_q      <= ZERO_W;
            divisor_q       <= ZERO_W;
            q_neg_q         <= 1'b0;
            busy_q          <= 1'b0;
            done_q          <= 1'b0;
            div_zero_q      <= 1'b0;
            hi_q            <= ZERO_W;
            lo_q            <= ZERO_W;
        end else begin
            state_q         <= state_d;
            count_q         <= count_d;
            core_dividend_q <= core_dividend_d;
            core_divisor_q  <= core_divisor_d;
            dividend_q      <= dividend_d;
            divisor_q       <= divisor_d;
            q_neg_q         <= q_neg_d;
            busy_q          <= busy_d;
            done_q          <= done_d;
            div_zero_q      <= div_zero_d;
            hi_q            <= hi_d;
            lo_q            <= lo_d;
        end
    end

    assign core_dividend = core_dividend_q;
    assign core_divisor  = core_divisor_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign div_zero      = div_zero_q;
    assign hi            = hi_q;
    assign lo            = lo_q;

endmodule

// File: tb/tb_div_sign_ctrl.sv
// -----------------------------------------------------------------------------
// tb_div_sign_ctrl
// Scoreboard bench for div_sign_ctrl: each accepted request pushes its
// expected HI/LO/div_zero (from 64-bit signed reference arithmetic); a
// negedge monitor pops and compares whenever done is seen. A behavioural
// unsigned divider stands in for the core.
// -----------------------------------------------------------------------------
module tb_div_sign_ctrl;

    localparam int W  = 32;
    localparam int CL = 2;

    logic          clk = 1'b0;
    logic          clr_n;
    logic          start;
    logic [W-1:0]  dividend;
    logic [W-1:0]  divisor;
    logic [W-1:0]  core_dividend;
    logic [W-1:0]  core_divisor;
    logic [W-1:0]  core_quotient;
    logic          busy;
    logic          done;
    logic          div_zero;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    typedef struct {
        logic [W-1:0] hi;
        logic [W-1:0] lo;
        logic         dz;
    } exp_t;

    exp_t         sb_q[$];
    int           checks   = 0;
    int           failures = 0;
    logic [W-1:0] exp_core_a = 32'd0;
    logic [W-1:0] exp_core_b = 32'd0;

    div_sign_ctrl #(.WIDTH(W), .CORE_LAT(CL)) dut (
        .clk           (clk),
        .clr_n         (clr_n),
        .start         (start),
        .dividend      (dividend),
        .divisor       (divisor),
        .core_dividend (core_dividend),
        .core_divisor  (core_divisor),
        .core_quotient (core_quotient),
        .busy          (busy),
        .done          (done),
        .div_zero      (div_zero),
        .hi            (hi),
        .lo            (lo)
    );

    // Clock generation.
    always #5 clk = ~clk;

    // Behavioural unsigned divider core.
    always_comb begin
        if (core_divisor == 32'd0) core_quotient = 32'hFFFF_FFFF;
        else                       core_quotient = core_dividend / core_divisor;
    end

    task automatic check_val(input string tag, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h expected=0x%08h", tag, act, exp);
        end
    endtask

    function automatic exp_t ref_div(input logic [W-1:0] a, input logic [W-1:0] b);
        exp_t   e;
        longint sa, sbv, q, r;
        if (b == 32'd0) begin
            e.hi = a;
            e.lo = 32'hFFFF_FFFF;
            e.dz = 1'b1;
        end else begin
            sa   = longint'($signed(a));
            sbv  = longint'($signed(b));
            q    = sa / sbv;
            r    = sa % sbv;
            e.lo = q[31:0];
            e.hi = r[31:0];
            e.dz = 1'b0;
        end
        return e;
    endfunction

    function automatic logic [W-1:0] mag(input logic [W-1:0] v);
        return v[W-1] ? (~v + 32'd1) : v;
    endfunction

    // Scoreboard monitor: every done pulse must match the oldest expectation.
    always @(negedge clk) begin
        if (clr_n && done) begin
            if (sb_q.size() == 0) begin
                check_val("unexpected_done", {31'd0, done}, 32'd0);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check_val("lo", lo, e.lo);
                check_val("hi", hi, e.hi);
                check_val("div_zero", {31'd0, div_zero}, {31'd0, e.dz});
            end
        end
    end

    task automatic check_zero_outputs(input string tag);
        check_val({tag, "_busy"},     {31'd0, busy},     32'd0);
        check_val({tag, "_done"},     {31'd0, done},     32'd0);
        check_val({tag, "_div_zero"}, {31'd0, div_zero}, 32'd0);
        check_val({tag, "_hi"},       hi,                32'd0);
        check_val({tag, "_lo"},       lo,                32'd0);
        check_val({tag, "_core_a"},   core_dividend,     32'd0);
        check_val({tag, "_core_b"},   core_divisor,      32'd0);
    endtask

    // Drive one request starting at the current negedge; return at the
    // negedge where done is seen. Operands are scrambled after acceptance.
    task automatic run_op(input logic [W-1:0] a, input logic [W-1:0] b,
                          output int lat, output int busy_cnt);
        start    = 1'b1;
        dividend = a;
        divisor  = b;
        sb_q.push_back(ref_div(a, b));
        if (b != 32'd0) begin
            exp_core_a = mag(a);
            exp_core_b = mag(b);
        end
        lat      = 0;
        busy_cnt = 0;
        for (int k = 1; k <= 20; k++) begin
            @(negedge clk);
            if (k == 1) begin
                start    = 1'b0;
                dividend = $urandom;
                divisor  = $urandom;
            end
            if (busy) busy_cnt++;
            if (done) begin
                lat = k;
                break;
            end
        end
        if (lat == 0) check_val("done_timeout", {31'd0, done}, 32'd1);
        check_val("core_dividend", core_dividend, exp_core_a);
        check_val("core_divisor",  core_divisor,  exp_core_b);
    endtask

    task automatic op_timed(input logic [W-1:0] a, input logic [W-1:0] b);
        int lat, bc;
        run_op(a, b, lat, bc);
        check_val("latency", lat, (b == 32'd0) ? 32'd1 : (CL + 1));
        check_val("busy_cycles", bc, (b == 32'd0) ? 32'd0 : CL);
    endtask

    typedef struct { logic [W-1:0] a; logic [W-1:0] b; } pair_t;

    initial begin
        pair_t tbl[6];
        int    lat, bc, wait_n;

        tbl[0] = '{32'd100,      32'd7};
        tbl[1] = '{-32'sd100,    32'd7};
        tbl[2] = '{32'd100,      -32'sd7};
        tbl[3] = '{-32'sd100,    -32'sd7};
        tbl[4] = '{32'h8000_0000, 32'hFFFF_FFFF};
        tbl[5] = '{32'h8000_0000, 32'd1};

        clr_n    = 1'b0;
        start    = 1'b0;
        dividend = 32'd0;
        divisor  = 32'd0;
        #12;
        check_zero_outputs("reset");
        @(negedge clk);
        clr_n = 1'b1;
        @(negedge clk);

        // Directed sign and extreme cases, with an idle cycle between each.
        foreach (tbl[i]) begin
            op_timed(tbl[i].a, tbl[i].b);
            @(negedge clk);
        end

        // Divide by zero, then a normal op back-to-back from DONE.
        op_timed(32'd55, 32'd0);
        op_timed(32'd9, 32'd3);
        @(negedge clk);

        // start with new operands while in WAIT must be ignored.
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        sb_q.push_back(ref_div(32'd100, 32'd7));
        exp_core_a = 32'd100;
        exp_core_b = 32'd7;
        @(negedge clk);
        dividend = 32'd8;
        divisor  = 32'd2;
        @(negedge clk);
        start  = 1'b0;
        wait_n = 0;
        while (!done && wait_n < 20) begin
            @(negedge clk);
            wait_n++;
        end
        check_val("wait_ignore_done", {31'd0, done}, 32'd1);
        // Back-to-back 8/2 accepted from DONE.
        op_timed(32'd8, 32'd2);
        repeat (4) @(negedge clk);
        check_val("hold_lo", lo, 32'd4);
        check_val("hold_hi", hi, 32'd0);

        // Asynchronous reset in the middle of WAIT discards the operation.
        start    = 1'b1;
        dividend = 32'd100;
        divisor  = 32'd7;
        @(negedge clk);
        start = 1'b0;
        check_val("pre_reset_busy", {31'd0, busy}, 32'd1);
        #2 clr_n = 1'b0;
        #1;
        check_zero_outputs("async_reset");
        sb_q.delete();
        exp_core_a = 32'd0;
        exp_core_b = 32'd0;
        @(negedge clk);
        clr_n = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check_val("no_done_after_reset", {31'd0, done}, 32'd0);
        end
        op_timed(32'd100, 32'd7);
        @(negedge clk);

        // Random requests, mixing back-to-back and gapped issue.
        for (int n = 0; n < 30; n++) begin
            logic [W-1:0] ra, rb;
            ra = $urandom;
            case ($urandom_range(0, 3))
                0:       rb = 32'd0;
                1:       rb = $urandom;
                2:       rb = 32'($urandom_range(1, 300));
                default: rb = -32'($urandom_range(1, 300));
            endcase
            op_timed(ra, rb);
            if ($urandom_range(0, 1) == 1) @(negedge clk);
        end

        repeat (4) @(negedge clk);
        check_val("scoreboard_empty", sb_q.size(), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/div_sign_ctrl.md
# div_sign_ctrl

Multi-cycle signed-division sequencer between the ALU operand bus and the unsigned 32-bit divider core. It accepts a signed dividend/divisor pair on a start pulse and drives magnitudes into the core. After the core has settled it applies sign correction, derives the remainder, and registers the result as HI (remainder) and LO (quotient) for the HI/LO register write-back. It also flags divide-by-zero without engaging the core.

## Interface
- WIDTH, 32: operand/result width.
- CORE_LAT, 2: settle cycles allowed for the combinational core (≥1).
- clk  in  1  system clock, rising edge.
- clr_n  in  1  asynchronous, active-low reset.
- start  in  1  request; sampled only in IDLE or DONE.
- dividend  in  WIDTH  signed dividend, sampled with start.
- divisor  in  WIDTH  signed divisor, sampled with start.
- core_dividend  out  WIDTH  registered |dividend| to core.
- core_divisor  out  WIDTH  registered |divisor| to core.
- core_quotient  in  WIDTH  unsigned quotient from core.
- busy  out  1  high in WAIT.
- done  out  1  one-cycle pulse; hi/lo/div_zero valid.
- div_zero  out  1  result came from a zero divisor.
- hi  out  WIDTH  signed remainder.
- lo  out  WIDTH  signed quotient.

## Operation
- States: IDLE, WAIT, DONE.
- IDLE/DONE + start, divisor≠0:
  - Register core_dividend = |dividend| and core_divisor = |divisor|, each unsigned WIDTH-bit.
  - Latch q_neg = sign(dividend) XOR sign(divisor), r_neg = sign(dividend), and the original dividend and divisor.
  - Load count = CORE_LAT−1; go to WAIT.
- IDLE/DONE + start, divisor=0:
  - Go straight to DONE.
  - Set hi = dividend, lo = all ones, div_zero = 1.
  - Core operands are unchanged.
- WAIT: decrement count each edge. At the edge where count==0:
  - lo = q_neg ? −core_quotient : core_quotient, computed mod 2^WIDTH.
  - hi = dividend_latched − lo·divisor_latched, using the low WIDTH bits of the product.
  - Clear div_zero; go to DONE.
- DONE: done=1 for exactly one cycle. Go to IDLE, or back to WAIT/DONE if start is present that cycle.
- Sign rules:
  - The quotient truncates toward zero.
  - The remainder takes the dividend's sign, so |hi| < |divisor|.
- Overflow: INT_MIN / −1 gives lo = 0x80000000 and hi = 0 (wraps; no flag).
- |INT_MIN| is 0x80000000 treated as unsigned, which the core handles correctly.
- start in WAIT is ignored. Operand changes in WAIT have no effect.
- hi, lo and div_zero hold their values until the next result is registered.
- Reset, at any time including mid-WAIT:
  - state = IDLE, count = 0.
  - busy, done, div_zero, hi, lo, core_dividend and core_divisor all reset to 0.
  - An in-flight operation is discarded.

## Timing
- Normal path: start sampled at edge E0. busy is high from E0 to E0+CORE_LAT. Results are registered at E0+CORE_LAT, and done is high for the following cycle.
- Latency: CORE_LAT edges, which is 2 with the default.
- Divide-by-zero path: results registered at E0; done is high the next cycle (latency 1); busy never asserts.
- Back-to-back: start during DONE is accepted. The next done comes CORE_LAT edges later. There is no idle bubble.
- core_quotient is sampled only at the final WAIT edge. The core must settle within CORE_LAT cycles of core operand update.
- All outputs are registered; none depends combinationally on inputs.

## Test plan
- 100 / 7, CORE_LAT=2:
  - busy for 2 cycles, then done.
  - lo = 14, hi = 2, div_zero = 0.
- Sign cases:
  - −100 / 7 → lo = 0xFFFFFFF2, hi = 0xFFFFFFFE.
  - 100 / −7 → lo = 0xFFFFFFF2, hi = 2.
  - −100 / −7 → lo = 14, hi = 0xFFFFFFFE.
- Extremes:
  - 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
  - 0x80000000 / 1 → lo = 0x80000000, hi = 0.
- 55 / 0:
  - done one cycle after start, busy never high.
  - div_zero = 1, hi = 55, lo = 0xFFFFFFFF.
  - A following 9 / 3 gives div_zero = 0, lo = 3, hi = 0.
- start pulsed with 8/2 during WAIT of 100/7:
  - Ignored; result is lo = 14, hi = 2.
  - Start during DONE with 8/2 gives lo = 4 two edges later.
- clr_n low mid-WAIT:
  - All outputs 0 immediately (asynchronous).
  - No done pulse after release.
  - Next start completes normally.
